// File: rtl/wb_regfile.sv
// Writeback stage: load extraction, result select and a 32x32 register file with write-through reads.
// Optional retired-instruction counter on instretW is built when WB_INSTRET_EN is defined.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       regWriteW,
    input  logic [1:0]                 resultSrcW,
    input  logic [2:0]                 funct3W,
    input  logic [XLEN-1:0]            ALUResultW,
    input  logic [XLEN-1:0]            RDW,
    input  logic [XLEN-1:0]            PCPlus4W,
    input  logic [XLEN-1:0]            extImmW,
    input  logic [$clog2(NREGS)-1:0]   RdW,
    input  logic                       validW,
    input  logic [$clog2(NREGS)-1:0]   A1D,
    input  logic [$clog2(NREGS)-1:0]   A2D,
    output logic [XLEN-1:0]            RD1D,
    output logic [XLEN-1:0]            RD2D,
    output logic [XLEN-1:0]            resultW
`ifdef WB_INSTRET_EN
    ,output logic [63:0]               instretW
`endif
);

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] load_data;
    logic            wr_en;
    logic            hit1;
    logic            hit2;

    // Byte/half selection by the low address bits, then sign or zero extension.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      f3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[8*off +: 8];
        h = word[16*off[1] +: 16];
        case (f3)
            3'b000:  load_extract = XLEN'(b);
            3'b001:  load_extract = XLEN'(h);
            3'b100:  load_extract = {{(XLEN-8){1'b0}}, b};
            3'b101:  load_extract = {{(XLEN-16){1'b0}}, h};
            default: load_extract = word;
        endcase
    endfunction

    assign load_data = load_extract(funct3W, ALUResultW[1:0], RDW);

    always_comb begin
        resultW = ALUResultW;
        case (resultSrcW)
            2'b00: resultW = ALUResultW;
            2'b01: resultW = load_data;
            2'b10: resultW = PCPlus4W;
            2'b11: resultW = extImmW;
            default: resultW = ALUResultW;
        endcase
    end

    assign wr_en = regWriteW && (RdW != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[RdW] <= resultW;
        end
    end

    // Write-through lets decode see a value committed in this same cycle.
    assign hit1 = wr_en && (RdW == A1D);
    assign hit2 = wr_en && (RdW == A2D);

    assign RD1D = (rst || A1D == '0) ? '0 : (hit1 ? resultW : regs[A1D]);
    assign RD2D = (rst || A2D == '0) ? '0 : (hit2 ? resultW : regs[A2D]);

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instret_q <= '0;
        else if (validW) instret_q <= instret_q + 64'd1;
    end

    assign instretW = instret_q;
`else
    logic unused_valid;
    assign unused_valid = validW;
`endif

endmodule
